// File: rtl/spi_master_engine.sv
// Bit-level SPI master: serialises one D_WIDTH word per transfer in any of the four SPI modes,
// with a programmable sclk half-period and optional back-to-back words under one chip select.
module spi_master_engine #(
  parameter int unsigned SLAVES     = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  cont,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0]    tx_data,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [SLAVES-1:0]     ss_n,
  output logic                  busy,
  output logic [D_WIDTH-1:0]    rx_data,
  output logic                  rx_valid
);

  localparam int unsigned EdgeW = $clog2(2 * D_WIDTH + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * D_WIDTH);

  typedef enum logic [1:0] {StIdle, StXfer, StHold} state_e;

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [EdgeW-1:0]       edge_q;
  logic                   cpha_q;
  logic                   cont_q;
  logic                   sclk_q;
  logic                   mosi_q;
  logic                   busy_q;
  logic                   rx_valid_q;
  logic [SLAVES-1:0]      ss_n_q;
  logic [D_WIDTH-1:0]     tx_sh_q;
  logic [D_WIDTH-1:0]     rx_sh_q;
  logic [D_WIDTH-1:0]     rx_data_q;

  logic [EdgeW-1:0]       edge_nxt;
  logic                   half_done;
  logic                   sample_edge;
  logic                   launch;
  logic                   launch_cpha;
  logic [SLAVES-1:0]      ss_sel;

  assign edge_nxt    = edge_q + EdgeW'(1);
  assign half_done   = (cnt_q == div_q);
  // Odd edges are leading; cpha selects whether leading or trailing edges sample miso.
  assign sample_edge = edge_nxt[0] ^ cpha_q;
  assign launch      = enable & ((state_q == StIdle) |
                                 ((state_q == StHold) & half_done & cont_q));
  assign launch_cpha = (state_q == StIdle) ? cpha : cpha_q;

  // An out-of-range address selects nothing, so the word runs with every ss_n high.
  always_comb begin
    ss_sel = '1;
    for (int i = 0; i < SLAVES; i++) begin
      ss_sel[i] = (addr != ADDR_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      cpha_q     <= 1'b0;
      cont_q     <= 1'b0;
      sclk_q     <= cpol;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      ss_n_q     <= '1;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: sclk_q <= cpol;
        StXfer: begin
          if (half_done) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            if (sample_edge) begin
              rx_sh_q <= {rx_sh_q[D_WIDTH-2:0], miso};
            end else if (cpha_q) begin
              mosi_q  <= tx_sh_q[D_WIDTH-1];
              tx_sh_q <= {tx_sh_q[D_WIDTH-2:0], 1'b0};
            end else if (edge_nxt != LastEdge) begin
              mosi_q  <= tx_sh_q[D_WIDTH-2];
              tx_sh_q <= {tx_sh_q[D_WIDTH-2:0], 1'b0};
            end
            if (edge_nxt == LastEdge) begin
              edge_q  <= '0;
              state_q <= StHold;
            end else begin
              edge_q <= edge_nxt;
            end
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
        StHold: begin
          if (half_done) begin
            cnt_q      <= '0;
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
            state_q    <= StIdle;
            ss_n_q     <= '1;
            busy_q     <= 1'b0;
            mosi_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      // Shared by an idle start and a continuous-mode relatch; overrides the HOLD exit above.
      if (launch) begin
        state_q <= StXfer;
        cnt_q   <= '0;
        edge_q  <= '0;
        div_q   <= clk_div;
        tx_sh_q <= tx_data;
        ss_n_q  <= ss_sel;
        busy_q  <= 1'b1;
        if (state_q == StIdle) begin
          sclk_q <= cpol;
          cpha_q <= cpha;
          cont_q <= cont;
        end
        if (!launch_cpha) begin
          mosi_q <= tx_data[D_WIDTH-1];
        end
      end
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
